wishbone_rr_arbiter: RTL and testbench
======================================

Name: wishbone_rr_arbiter

Overview:
- Round-robin Wishbone (pipelined-mode) arbiter that shares one slave port among NUM_MASTERS requesters.
- Typical use is several masters (UART bridge, LED sequencer, test master) sharing the counter peripheral.
- Grants the bus per cycle-window (while the granted master holds CYC), routes request and response signals, and aborts windows that exceed a hold limit.

Parameters:
NUM_MASTERS, 2, number of requesting masters (2..8).
ADDR_WIDTH, 8, Wishbone address width.
DATA_WIDTH, 6, Wishbone data width.
MAX_HOLD, 64, max cycles a master may hold a grant before forced release (>=4).

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-high
i_m_cyc  in  NUM_MASTERS  per-master CYC
i_m_stb  in  NUM_MASTERS  per-master STB
i_m_we  in  NUM_MASTERS  per-master WE
i_m_addr  in  NUM_MASTERS*ADDR_WIDTH  per-master address, master k at bits [k*ADDR_WIDTH +: ADDR_WIDTH]
i_m_data  in  NUM_MASTERS*DATA_WIDTH  per-master write data, same packing
o_m_ack  out  NUM_MASTERS  per-master ACK
o_m_stall  out  NUM_MASTERS  per-master STALL
o_m_err  out  NUM_MASTERS  per-master ERR (hold-limit abort)
o_m_data  out  DATA_WIDTH  read data, broadcast; valid only with own ACK
o_s_cyc, o_s_stb, o_s_we  out  1  slave-side request
o_s_addr  out  ADDR_WIDTH  slave address
o_s_data  out  DATA_WIDTH  slave write data
i_s_ack, i_s_stall  in  1  slave response
i_s_data  in  DATA_WIDTH  slave read data
o_grant  out  NUM_MASTERS  one-hot current grant (debug/status)

Behaviour:
- States: IDLE, GRANT, ABORT. Registered: state, grant index, last-granted index, hold counter (clog2(MAX_HOLD+1) bits).
- Reset:
  - state=IDLE, grant=none, last=NUM_MASTERS-1, so master 0 wins first.
  - All outputs take their IDLE values: o_s_* = 0, o_m_ack = 0, o_m_err = 0, o_m_stall = all 1, o_grant = 0, o_m_data = i_s_data.
- IDLE:
  - If any i_m_cyc is high, select the first requester searching from last+1 upward, wrapping modulo NUM_MASTERS.
  - Next edge: state=GRANT, grant=selected, last=selected, hold=0.
  - Arbitration latency is 1 cycle. All masters see stall=1 while in IDLE.
- GRANT (granted master g):
  - o_s_cyc/stb/we/addr/data = master g inputs, combinational, zero added latency.
  - o_m_ack[g] = i_s_ack; o_m_stall[g] = i_s_stall. Every other master sees ack=0, stall=1.
  - Releases when i_m_cyc[g]=0: next state IDLE; o_s_cyc drops in the same cycle as i_m_cyc[g].
  - Always one IDLE cycle between grants, even with other requests pending.
  - Hold counter increments every GRANT cycle and saturates.
- Hold limit:
  - When hold reaches MAX_HOLD-1 with i_m_cyc[g] still high, the next edge goes to ABORT.
- ABORT (exactly 1 cycle):
  - o_s_cyc=0, o_s_stb=0.
  - o_m_err[g]=1; o_m_stall[g]=1; all o_m_ack=0.
  - Then IDLE. last=g, so g has lowest priority next time.
  - A master must drop CYC after ERR. If it re-asserts, it re-arbitrates normally.
- Slave responses:
  - An i_s_ack arriving in IDLE/ABORT (late ack from an aborted window) is discarded and not routed.
- Simultaneous events:
  - Release and new requests in the same cycle: release wins, arbitration happens in the following IDLE cycle.
  - Granted master dropping CYC in the same cycle the hold limit is reached: normal release, no ERR.
- Reset mid-transfer: immediate return to reset values. The slave sees CYC fall asynchronously.
- o_grant is one-hot of g in GRANT/ABORT, 0 in IDLE.

Decomposition:
- Shared package wb_pkg holds:
  - arb_state_t enum {IDLE, GRANT, ABORT};
  - WB_ADDR_WIDTH/WB_DATA_WIDTH defaults;
  - ADDR_COUNTER constant, reused by bench.
- One sub-module: rr_priority_pick.
  - Combinational: req vector + last index -> next index + valid.
  - Unit-testable separately.

Test Plan:
- Reset; master 0 single write addr 0x00 data 0x15 -> grant appears 1 cycle after cyc; slave sees we=1 addr 0x00 data 0x15; ack returned on o_m_ack[0] only; slave read back = 0x15.
- Masters 0 and 1 request continuously, each releasing after one transfer -> grants alternate 0,1,0,1 with exactly one IDLE cycle between each.
- Master 1 holds the grant while master 0 requests -> o_m_stall[0]=1 and o_m_ack[0]=0 throughout; master 0 granted 1 cycle after master 1 releases.
- Master 0 holds cyc for 70 cycles with MAX_HOLD=64 -> o_m_err[0] pulses for 1 cycle after 64 GRANT cycles; o_s_cyc=0 that cycle; next grant goes to master 1 if it is requesting.
- i_s_ack injected during IDLE -> no o_m_ack asserted anywhere.
- i_rst asserted mid-GRANT -> o_s_cyc=0 immediately, o_grant=0; after reset, master 0 wins the first arbitration.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared Wishbone arbiter types and bus defaults
package wb_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, ABORT} arb_state_t;
  localparam int WB_ADDR_WIDTH = 8;
  localparam int WB_DATA_WIDTH = 6;
  localparam logic [WB_ADDR_WIDTH-1:0] ADDR_COUNTER = 8'h00;
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: first set request after last, wrapping modulo N
module rr_priority_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] pick,
  output logic          valid
);
  always_comb begin
    pick  = '0;
    valid = |req;
    // scan farthest-first so the nearest requester after last overwrites
    for (int i = N; i >= 1; i--)
      if (req[(int'(last) + i) % N]) pick = IW'((int'(last) + i) % N);
  end
endmodule

// File: rtl/wishbone_rr_arbiter.sv
// wishbone_rr_arbiter: round-robin pipelined Wishbone arbiter with hold-limit abort
module wishbone_rr_arbiter
  import wb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH  = WB_DATA_WIDTH,
  parameter int MAX_HOLD    = 64
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [NUM_MASTERS-1:0]            i_m_cyc,
  input  logic [NUM_MASTERS-1:0]            i_m_stb,
  input  logic [NUM_MASTERS-1:0]            i_m_we,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] i_m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] i_m_data,
  output logic [NUM_MASTERS-1:0]            o_m_ack,
  output logic [NUM_MASTERS-1:0]            o_m_stall,
  output logic [NUM_MASTERS-1:0]            o_m_err,
  output logic [DATA_WIDTH-1:0]             o_m_data,
  output logic                              o_s_cyc,
  output logic                              o_s_stb,
  output logic                              o_s_we,
  output logic [ADDR_WIDTH-1:0]             o_s_addr,
  output logic [DATA_WIDTH-1:0]             o_s_data,
  input  logic                              i_s_ack,
  input  logic                              i_s_stall,
  input  logic [DATA_WIDTH-1:0]             i_s_data,
  output logic [NUM_MASTERS-1:0]            o_grant
);
  localparam int IW = $clog2(NUM_MASTERS);
  localparam int HW = $clog2(MAX_HOLD + 1);
  arb_state_t state, state_n;
  logic [IW-1:0] g, last, pick;
  logic [HW-1:0] hold;
  logic [NUM_MASTERS-1:0] oh;
  logic pick_valid, held, at_limit, granted;
  rr_priority_pick #(.N(NUM_MASTERS), .IW(IW)) u_pick (
    .req  (i_m_cyc),
    .last (last),
    .pick (pick),
    .valid(pick_valid)
  );
  assign held     = i_m_cyc[g];
  assign at_limit = hold == HW'(MAX_HOLD - 1);
  assign oh       = NUM_MASTERS'(1) << g;
  assign granted  = state == GRANT;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      g    <= '0;
      last <= IW'(NUM_MASTERS - 1);
      hold <= '0;
    end else if (state == IDLE && pick_valid) begin
      g    <= pick;
      last <= pick;
      hold <= '0;
    end else if (granted && hold != HW'(MAX_HOLD)) begin
      hold <= hold + 1'b1;
    end
  // release takes priority over the hold limit
  always_comb
    state_n = state == IDLE  ? (pick_valid ? GRANT : IDLE) :
              state == GRANT ? (!held ? IDLE : at_limit ? ABORT : GRANT) : IDLE;
  always_comb begin
    o_s_cyc   = granted & held;
    o_s_stb   = granted & held & i_m_stb[g];
    o_s_we    = granted & i_m_we[g];
    o_s_addr  = granted ? i_m_addr[g*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    o_s_data  = granted ? i_m_data[g*DATA_WIDTH +: DATA_WIDTH] : '0;
    o_m_ack   = (granted && i_s_ack) ? oh : '0;
    o_m_stall = ~((granted && !i_s_stall) ? oh : '0);
    o_m_err   = state == ABORT ? oh : '0;
    o_grant   = state != IDLE ? oh : '0;
    o_m_data  = i_s_data;
  end
endmodule

// File: tb/tb_wishbone_rr_arbiter.sv
// tb_wishbone_rr_arbiter: directed checks of grant, routing, hold abort and reset
module tb_wishbone_rr_arbiter;
  import wb_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] m_cyc, m_stb, m_we, m_ack, m_stall, m_err, grant;
  logic [15:0] m_addr;
  logic [11:0] m_data;
  logic [5:0] m_rdata, s_wdata, s_data, sdrv;
  logic [7:0] s_addr;
  logic s_cyc, s_stb, s_we, s_ack, s_stall, auto, force_ack;
  logic [5:0] sreg = '0;
  int total = 0;
  int bad = 0;
  wishbone_rr_arbiter dut (
    .i_clk(clk), .i_rst(rst),
    .i_m_cyc(m_cyc), .i_m_stb(m_stb), .i_m_we(m_we), .i_m_addr(m_addr), .i_m_data(m_data),
    .o_m_ack(m_ack), .o_m_stall(m_stall), .o_m_err(m_err), .o_m_data(m_rdata),
    .o_s_cyc(s_cyc), .o_s_stb(s_stb), .o_s_we(s_we), .o_s_addr(s_addr), .o_s_data(s_wdata),
    .i_s_ack(s_ack), .i_s_stall(s_stall), .i_s_data(s_data),
    .o_grant(grant)
  );
  always #5 clk = ~clk;
  assign s_ack  = auto ? (s_cyc & s_stb) : force_ack;
  assign s_data = auto ? sreg : sdrv;
  always @(posedge clk)
    if (s_cyc && s_stb && s_we && s_ack && s_addr == ADDR_COUNTER) sreg <= s_wdata;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    m_cyc = '0; m_stb = '0; m_we = '0; m_addr = '0; m_data = '0;
    auto = 1'b1; force_ack = 1'b0; s_stall = 1'b0; sdrv = '0;
    tick;
    rst = 1'b0;
  endtask
  task automatic test_reset;
    do_reset;
    rst = 1'b1;
    auto = 1'b0;
    sdrv = 6'h2A;
    tick;
    total++;
    if ({grant, s_cyc, s_stb, s_we, s_addr, s_wdata} !== 19'h0) begin
      bad++; $display("FAIL reset_slave: got %h want 0", {grant, s_cyc, s_stb, s_we, s_addr, s_wdata});
    end
    total++;
    if ({m_ack, m_err, m_stall} !== 6'b00_00_11) begin
      bad++; $display("FAIL reset_master: got %b want 000011", {m_ack, m_err, m_stall});
    end
    total++;
    if (m_rdata !== 6'h2A) begin
      bad++; $display("FAIL reset_rdata: got %h want 2a", m_rdata);
    end
    rst = 1'b0;
    auto = 1'b1;
  endtask
  task automatic test_single_write;
    do_reset;
    m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b01;
    m_addr[7:0] = ADDR_COUNTER; m_data[5:0] = 6'h15;
    #1;
    total++;
    if ({grant, m_stall} !== 4'b00_11) begin
      bad++; $display("FAIL sw_idle: got %b want 0011", {grant, m_stall});
    end
    tick;
    total++;
    if ({grant, s_cyc, s_we, s_addr, s_wdata} !== {2'b01, 1'b1, 1'b1, 8'h00, 6'h15}) begin
      bad++; $display("FAIL sw_slave: got %h want %h", {grant, s_cyc, s_we, s_addr, s_wdata}, {2'b01, 1'b1, 1'b1, 8'h00, 6'h15});
    end
    total++;
    if (m_ack !== 2'b01) begin
      bad++; $display("FAIL sw_ack: got %b want 01", m_ack);
    end
    tick;
    m_cyc = 2'b00;
    #1;
    total++;
    if (s_cyc !== 1'b0) begin
      bad++; $display("FAIL sw_release: got %b want 0", s_cyc);
    end
    tick;
    m_cyc = 2'b01; m_we = 2'b00;
    #1;
    total++;
    if (grant !== 2'b00) begin
      bad++; $display("FAIL sw_gap: got %b want 00", grant);
    end
    tick;
    total++;
    if ({m_ack, m_rdata} !== {2'b01, 6'h15}) begin
      bad++; $display("FAIL sw_read: got %h want %h", {m_ack, m_rdata}, {2'b01, 6'h15});
    end
    m_cyc = 2'b00;
    tick;
  endtask
  task automatic test_alternate;
    logic [1:0] oh;
    do_reset;
    m_stb = 2'b11;
    for (int k = 0; k < 4; k++) begin
      oh = 2'b01 << (k % 2);
      m_cyc = 2'b11;
      #1;
      total++;
      if ({grant, m_stall} !== 4'b00_11) begin
        bad++; $display("FAIL alt_idle[%0d]: got %b want 0011", k, {grant, m_stall});
      end
      tick;
      total++;
      if ({grant, m_ack, m_stall} !== {oh, oh, ~oh}) begin
        bad++; $display("FAIL alt_grant[%0d]: got %b want %b", k, {grant, m_ack, m_stall}, {oh, oh, ~oh});
      end
      tick;
      m_cyc[k % 2] = 1'b0;
      #1;
      total++;
      if ({grant, s_cyc} !== {oh, 1'b0}) begin
        bad++; $display("FAIL alt_release[%0d]: got %b want %b", k, {grant, s_cyc}, {oh, 1'b0});
      end
      tick;
    end
    m_cyc = 2'b00;
    tick;
  endtask
  task automatic test_hold_off;
    do_reset;
    m_stb = 2'b11;
    m_cyc = 2'b10;
    tick;
    m_cyc = 2'b11;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if ({m_stall[0], m_ack[0], grant} !== 4'b1_0_10) begin
        bad++; $display("FAIL ho_blocked[%0d]: got %b want 1010", i, {m_stall[0], m_ack[0], grant});
      end
      tick;
    end
    m_cyc = 2'b01;
    #1;
    total++;
    if ({grant, m_stall[0]} !== 3'b10_1) begin
      bad++; $display("FAIL ho_release: got %b want 101", {grant, m_stall[0]});
    end
    tick;
    total++;
    if (grant !== 2'b00) begin
      bad++; $display("FAIL ho_gap: got %b want 00", grant);
    end
    tick;
    total++;
    if ({grant, m_ack} !== 4'b01_01) begin
      bad++; $display("FAIL ho_grant0: got %b want 0101", {grant, m_ack});
    end
    m_cyc = 2'b00;
    tick;
  endtask
  task automatic test_hold_limit;
    do_reset;
    m_stb = 2'b01;
    m_cyc = 2'b01;
    tick;
    for (int i = 0; i < 64; i++) begin
      if (i == 10) m_cyc[1] = 1'b1;
      #1;
      total++;
      if ({grant, m_err, s_cyc} !== 5'b01_00_1) begin
        bad++; $display("FAIL hl_grant[%0d]: got %b want 01001", i, {grant, m_err, s_cyc});
      end
      tick;
    end
    total++;
    if ({grant, m_err, s_cyc, s_stb, m_ack, m_stall} !== 10'b01_01_0_0_00_11) begin
      bad++; $display("FAIL hl_abort: got %b want 0101000011", {grant, m_err, s_cyc, s_stb, m_ack, m_stall});
    end
    tick;
    total++;
    if ({grant, m_err} !== 4'b00_00) begin
      bad++; $display("FAIL hl_idle: got %b want 0000", {grant, m_err});
    end
    tick;
    total++;
    if (grant !== 2'b10) begin
      bad++; $display("FAIL hl_next: got %b want 10", grant);
    end
    m_cyc = 2'b00;
    tick;
  endtask
  task automatic test_late_ack;
    do_reset;
    auto = 1'b0;
    force_ack = 1'b1;
    #1;
    total++;
    if (m_ack !== 2'b00) begin
      bad++; $display("FAIL la_idle_empty: got %b want 00", m_ack);
    end
    m_cyc = 2'b01; m_stb = 2'b01;
    #1;
    total++;
    if (m_ack !== 2'b00) begin
      bad++; $display("FAIL la_idle_req: got %b want 00", m_ack);
    end
    tick;
    total++;
    if (m_ack !== 2'b01) begin
      bad++; $display("FAIL la_grant_routes: got %b want 01", m_ack);
    end
    m_cyc = 2'b00;
    auto = 1'b1;
    force_ack = 1'b0;
    tick;
  endtask
  task automatic test_reset_mid;
    do_reset;
    m_cyc = 2'b10; m_stb = 2'b10;
    tick;
    total++;
    if ({grant, s_cyc} !== 3'b10_1) begin
      bad++; $display("FAIL rm_before: got %b want 101", {grant, s_cyc});
    end
    rst = 1'b1;
    #1;
    total++;
    if ({grant, s_cyc, m_stall} !== 5'b00_0_11) begin
      bad++; $display("FAIL rm_async: got %b want 00011", {grant, s_cyc, m_stall});
    end
    m_cyc = 2'b11;
    tick;
    rst = 1'b0;
    #1;
    total++;
    if (grant !== 2'b00) begin
      bad++; $display("FAIL rm_idle: got %b want 00", grant);
    end
    tick;
    total++;
    if (grant !== 2'b01) begin
      bad++; $display("FAIL rm_first: got %b want 01", grant);
    end
    m_cyc = 2'b00;
    tick;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: timeout");
    $fatal(1);
  end
  initial begin
    test_reset;
    test_single_write;
    test_alternate;
    test_hold_off;
    test_hold_limit;
    test_late_ack;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
